// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle CPU. It walks each instruction through
//   fetch / decode / execute / memory / writeback and drives the datapath
//   control lines. PCWRITE and BRANCH feed the downstream PC-update gate,
//   where BRANCH is qualified by the ALU BranchTaken flag.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous reset, active high
//   Op         in   6  opcode from the instruction register (valid from DECODE)
//   MEM_READY  in   1  memory completes the current read/write this cycle
//   PCWRITE    out  1  unconditional PC write
//   BRANCH     out  1  conditional PC write
//   IorD       out  1  memory address select: 0=PC, 1=ALUOut
//   MemRead    out  1  memory read request
//   MemWrite   out  1  memory write request
//   IRWrite    out  1  load instruction register
//   MemtoReg   out  1  register write data: 1=MDR, 0=ALUOut
//   RegDst     out  1  write register: 1=rd, 0=rt
//   RegWrite   out  1  register file write enable
//   ALUSrcA    out  1  0=PC, 1=A register
//   ALUSrcB    out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   ALUOp      out  2  00=add, 01=sub, 10=funct-decoded
//   PCSource   out  2  00=ALU result, 01=ALUOut, 10=jump target
//   ILLEGAL    out  1  sticky flag: an undefined opcode reached DECODE
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       MEM_READY,
  output logic       PCWRITE,
  output logic       BRANCH,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ILLEGAL
);

  // 12 states in a 4-bit register; the four spare encodings fall to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // State register and sticky illegal-opcode flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      ILLEGAL <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (MEM_READY) state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BEQ;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDIEX;
            default: begin
              state   <= S_FETCH;
              ILLEGAL <= 1'b1;
            end
          endcase
        end
        // Op is looked at again here; if it no longer names a memory op the
        // instruction is dropped rather than guessing a direction.
        S_MEMADR: begin
          if (Op == OP_LW)      state <= S_MEMRD;
          else if (Op == OP_SW) state <= S_MEMWR;
          else                  state <= S_FETCH;
        end
        S_MEMRD:  if (MEM_READY) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (MEM_READY) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BEQ:    state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore on state, FETCH strobes gated by MEM_READY)
  // -------------------------------------------------------------------------
  always_comb begin
    PCWRITE  = 1'b0;
    BRANCH   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and the IR load commit only on the cycle memory delivers.
        IRWrite = MEM_READY;
        PCWRITE = MEM_READY;
      end
      S_DECODE: ALUSrcB = 2'b11;  // branch target precompute
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        BRANCH   = 1'b1;
        PCSource = 2'b01;
      end
      S_JUMP: begin
        PCWRITE  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase

    // Reset kills every architectural write strobe immediately, so an
    // instruction caught mid-flight leaves no trace.
    if (rst) begin
      PCWRITE  = 1'b0;
      BRANCH   = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed vector table, hand-written reset-abort sequences, and a
//   randomized run checked against an instruction-level phase-plan model.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Control word: {PCWRITE,BRANCH,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //                RegDst,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  localparam logic [15:0] C_FW   = 16'h1010; // fetch waiting: MemRead, SrcB=01
  localparam logic [15:0] C_FR   = 16'h9410; // fetch done: + PCWRITE, IRWrite
  localparam logic [15:0] C_D    = 16'h0030; // SrcB=11
  localparam logic [15:0] C_MA   = 16'h0060; // SrcA=1, SrcB=10 (also ADDIEX)
  localparam logic [15:0] C_MR   = 16'h3000; // IorD, MemRead
  localparam logic [15:0] C_MWB  = 16'h0280; // MemtoReg, RegWrite
  localparam logic [15:0] C_MW   = 16'h2800; // IorD, MemWrite
  localparam logic [15:0] C_EX   = 16'h0048; // SrcA=1, ALUOp=10
  localparam logic [15:0] C_AWB  = 16'h0180; // RegDst, RegWrite
  localparam logic [15:0] C_BQ   = 16'h4045; // BRANCH, SrcA, ALUOp=01, PCSrc=01
  localparam logic [15:0] C_JP   = 16'h8002; // PCWRITE, PCSrc=10
  localparam logic [15:0] C_AWI  = 16'h0080; // RegWrite
  localparam logic [15:0] RST_KILL = 16'hCC80; // PCWRITE,BRANCH,MemWrite,IRWrite,RegWrite

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       MEM_READY;
  logic       PCWRITE, BRANCH, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ILLEGAL;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [15:0] ctl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Op(Op), .MEM_READY(MEM_READY),
    .PCWRITE(PCWRITE), .BRANCH(BRANCH), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .ILLEGAL(ILLEGAL)
  );

  assign ctl = {PCWRITE, BRANCH, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic chk(input string name, input logic [15:0] ec, input logic ei);
    tests++;
    if (ctl !== ec || ILLEGAL !== ei) begin
      fails++;
      $display("FAIL %s: got ctl=%h ILLEGAL=%b, expected ctl=%h ILLEGAL=%b",
               name, ctl, ILLEGAL, ec, ei);
    end
  endtask

  // One cycle: drive just after the edge, check mid-cycle, advance.
  task automatic cyc(input logic r, input logic rdy, input logic [5:0] op,
                     input logic [15:0] ec, input logic ei, input string name);
    rst = r; MEM_READY = rdy; Op = op;
    @(negedge clk);
    chk(name, ec, ei);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        r;
    logic        rdy;
    logic [5:0]  op;
    logic [15:0] c;
    logic        ill;
  } vec_t;

  vec_t tbl[33];

  // ---- behavioural model: an instruction is a list of phases -----------
  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_AWB,
                    P_BQ, P_JP, P_AE, P_AWI} phase_t;
  phase_t plan[$];
  logic   ill_m;

  function automatic logic [15:0] word(input phase_t p, input logic rdy, input logic r);
    logic [15:0] w;
    case (p)
      P_F:   w = rdy ? C_FR : C_FW;
      P_D:   w = C_D;
      P_MA:  w = C_MA;
      P_MR:  w = C_MR;
      P_MWB: w = C_MWB;
      P_MW:  w = C_MW;
      P_EX:  w = C_EX;
      P_AWB: w = C_AWB;
      P_BQ:  w = C_BQ;
      P_JP:  w = C_JP;
      P_AE:  w = C_MA;
      default: w = C_AWI;
    endcase
    if (r) w = w & ~RST_KILL;
    return w;
  endfunction

  task automatic model_step(input logic r, input logic rdy, input logic [5:0] op);
    phase_t cur;
    cur = plan[0];
    if (r) begin
      plan.delete(); plan.push_back(P_F); ill_m = 1'b0;
    end else if ((cur == P_F || cur == P_MR || cur == P_MW) && !rdy) begin
      // memory not done: phase repeats
    end else begin
      void'(plan.pop_front());
      if (cur == P_F) plan.push_back(P_D);
      else if (cur == P_D) begin
        case (op)
          OP_LW:    begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_MWB); end
          OP_SW:    begin plan.push_back(P_MA); plan.push_back(P_MW); end
          OP_RTYPE: begin plan.push_back(P_EX); plan.push_back(P_AWB); end
          OP_BEQ:   plan.push_back(P_BQ);
          OP_J:     plan.push_back(P_JP);
          OP_ADDI:  begin plan.push_back(P_AE); plan.push_back(P_AWI); end
          default:  ill_m = 1'b1;
        endcase
      end
      if (plan.size() == 0) plan.push_back(P_F);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op_r;
    logic       r_r, rdy_r;

    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;  ops[3] = OP_BEQ;
    ops[4] = OP_J;     ops[5] = OP_ADDI; ops[6] = OP_BAD; ops[7] = 6'b010101;

    // r, rdy, op, expected control word, expected ILLEGAL
    tbl[0]  = '{1'b1, 1'b1, OP_LW,    C_FW,  1'b0}; // reset forces strobes low
    tbl[1]  = '{1'b0, 1'b0, OP_LW,    C_FW,  1'b0}; // fetch wait x3
    tbl[2]  = '{1'b0, 1'b0, OP_LW,    C_FW,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, OP_LW,    C_FW,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, OP_LW,    C_FR,  1'b0}; // LW: 5 cycles
    tbl[5]  = '{1'b0, 1'b1, OP_LW,    C_D,   1'b0};
    tbl[6]  = '{1'b0, 1'b1, OP_LW,    C_MA,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, OP_LW,    C_MR,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, OP_LW,    C_MWB, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, OP_SW,    C_FR,  1'b0}; // SW with 2 wait cycles
    tbl[10] = '{1'b0, 1'b1, OP_SW,    C_D,   1'b0};
    tbl[11] = '{1'b0, 1'b1, OP_SW,    C_MA,  1'b0};
    tbl[12] = '{1'b0, 1'b0, OP_SW,    C_MW,  1'b0};
    tbl[13] = '{1'b0, 1'b0, OP_SW,    C_MW,  1'b0};
    tbl[14] = '{1'b0, 1'b1, OP_SW,    C_MW,  1'b0};
    tbl[15] = '{1'b0, 1'b1, OP_BEQ,   C_FR,  1'b0}; // BEQ
    tbl[16] = '{1'b0, 1'b1, OP_BEQ,   C_D,   1'b0};
    tbl[17] = '{1'b0, 1'b1, OP_BEQ,   C_BQ,  1'b0};
    tbl[18] = '{1'b0, 1'b1, OP_J,     C_FR,  1'b0}; // J
    tbl[19] = '{1'b0, 1'b1, OP_J,     C_D,   1'b0};
    tbl[20] = '{1'b0, 1'b1, OP_J,     C_JP,  1'b0};
    tbl[21] = '{1'b0, 1'b1, OP_BAD,   C_FR,  1'b0}; // illegal opcode
    tbl[22] = '{1'b0, 1'b1, OP_BAD,   C_D,   1'b0};
    tbl[23] = '{1'b0, 1'b1, OP_RTYPE, C_FR,  1'b1}; // sticky over R-type
    tbl[24] = '{1'b0, 1'b1, OP_RTYPE, C_D,   1'b1};
    tbl[25] = '{1'b0, 1'b1, OP_RTYPE, C_EX,  1'b1};
    tbl[26] = '{1'b0, 1'b1, OP_RTYPE, C_AWB, 1'b1};
    tbl[27] = '{1'b0, 1'b1, OP_ADDI,  C_FR,  1'b1}; // ADDI
    tbl[28] = '{1'b0, 1'b1, OP_ADDI,  C_D,   1'b1};
    tbl[29] = '{1'b0, 1'b1, OP_ADDI,  C_MA,  1'b1};
    tbl[30] = '{1'b0, 1'b1, OP_ADDI,  C_AWI, 1'b1};
    tbl[31] = '{1'b1, 1'b1, OP_RTYPE, C_FW,  1'b1}; // rst: flag still set this cycle
    tbl[32] = '{1'b0, 1'b0, OP_RTYPE, C_FW,  1'b0}; // cleared after the edge

    rst = 1'b1; MEM_READY = 1'b0; Op = OP_RTYPE;
    @(posedge clk); #1;

    for (int i = 0; i < 33; i++)
      cyc(tbl[i].r, tbl[i].rdy, tbl[i].op, tbl[i].c, tbl[i].ill,
          $sformatf("vec%0d", i));

    // Reset during MEMWR with memory ready: no write, back to FETCH.
    cyc(1'b0, 1'b1, OP_SW, C_FR, 1'b0, "sw_abort_fetch");
    cyc(1'b0, 1'b1, OP_SW, C_D,  1'b0, "sw_abort_decode");
    cyc(1'b0, 1'b1, OP_SW, C_MA, 1'b0, "sw_abort_memadr");
    cyc(1'b1, 1'b1, OP_SW, 16'h2000, 1'b0, "sw_abort_memwr");
    cyc(1'b0, 1'b0, OP_SW, C_FW, 1'b0, "sw_abort_refetch");

    // Reset during MEMWB: register write suppressed.
    cyc(1'b0, 1'b1, OP_LW, C_FR,  1'b0, "lw_abort_fetch");
    cyc(1'b0, 1'b1, OP_LW, C_D,   1'b0, "lw_abort_decode");
    cyc(1'b0, 1'b1, OP_LW, C_MA,  1'b0, "lw_abort_memadr");
    cyc(1'b0, 1'b1, OP_LW, C_MR,  1'b0, "lw_abort_memrd");
    cyc(1'b1, 1'b1, OP_LW, 16'h0200, 1'b0, "lw_abort_memwb");
    cyc(1'b0, 1'b1, OP_LW, C_FR,  1'b0, "lw_abort_refetch");

    // Randomized run against the phase-plan model.
    rst = 1'b1; MEM_READY = 1'b0;
    @(posedge clk); #1;
    plan.delete(); plan.push_back(P_F); ill_m = 1'b0;
    op_r = OP_RTYPE;
    for (int n = 0; n < 800; n++) begin
      // Opcode may only change while fetching; it holds for the instruction.
      if (plan[0] == P_F) op_r = ops[$urandom_range(0, 7)];
      r_r   = ($urandom_range(0, 39) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      cyc(r_r, rdy_r, op_r, word(plan[0], rdy_r, r_r), ill_m,
          $sformatf("rand%0d", n));
      model_step(r_r, rdy_r, op_r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
